// File: rtl/fx_writeback_unit.sv
// FX result writeback: in-order result queue feeding the GPR write port,
// with CR0 generation from the head entry and architected XER SO/OV/CA tracking.
module fx_writeback_unit #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FXUnitCode = 0
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        outputEnable_i,
    input  logic [1:0]  functionalUnitCode_i,
    input  logic        is64Bit_i,
    input  logic [5:0]  regWritebackAddress_i,
    input  logic [63:0] regWritebackVal_i,
    input  logic        conditionRegWriteEnable_i,
    input  logic        carry_i,
    input  logic        overflow_i,
    input  logic        gprWriteReady_i,
    output logic        gprWriteEnable_o,
    output logic [5:0]  gprWriteAddress_o,
    output logic [63:0] gprWriteData_o,
    output logic        crWriteEnable_o,
    output logic [3:0]  crField_o,
    output logic        xerSO_o,
    output logic        xerOV_o,
    output logic        xerCA_o,
    output logic        stall_o,
    output logic        dropError_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;
        logic              is64;
        logic              cr_en;
        logic              carry;
        logic              overflow;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              hit;
    logic              enq;
    logic              deq;
    logic              drop;
    logic              neg;
    logic              zero;
    logic              xer_so;
    logic              xer_ov;
    logic              xer_ca;
    logic              drop_q;

    // Queue control; a full queue still accepts when the head leaves this cycle
    always_comb begin
        empty = (count == '0);
        full  = (count == CNT_W'(DEPTH));
        head  = mem[rd_ptr];
        hit   = outputEnable_i && (functionalUnitCode_i == 2'(FXUnitCode));
        deq   = !empty && gprWriteReady_i;
        enq   = hit && (!full || deq);
        drop  = hit && full && !deq;
    end

    // CR0 sign/zero test on the full doubleword or the low word (bits 32:63)
    always_comb begin
        neg  = head.is64 ? head.val[63] : head.val[31];
        zero = head.is64 ? (head.val == '0) : (head.val[31:0] == 32'd0);
    end

    always_comb begin
        gprWriteEnable_o  = !empty;
        gprWriteAddress_o = empty ? '0 : head.addr;
        gprWriteData_o    = empty ? '0 : head.val;
        crWriteEnable_o   = !empty && head.cr_en;
        crField_o[3]      = !empty && neg;
        crField_o[2]      = !empty && !neg && !zero;
        crField_o[1]      = !empty && zero;
        crField_o[0]      = xer_so || (!empty && head.overflow);
        xerSO_o           = xer_so;
        xerOV_o           = xer_ov;
        xerCA_o           = xer_ca;
        stall_o           = (count >= CNT_W'(DEPTH - 1));
        dropError_o       = drop_q;
    end

    // Entry storage needs no reset: it is only observed through count
    always_ff @(posedge clock_i) begin
        if (enq) begin
            mem[wr_ptr] <= '{addr:     regWritebackAddress_i,
                             val:      regWritebackVal_i,
                             is64:     is64Bit_i,
                             cr_en:    conditionRegWriteEnable_i,
                             carry:    carry_i,
                             overflow: overflow_i};
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            xer_so <= 1'b0;
            xer_ov <= 1'b0;
            xer_ca <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop;
            if (enq) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (deq) begin
                rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
                xer_ca <= head.carry;
                xer_ov <= head.overflow;
                xer_so <= xer_so || head.overflow;
            end
            if (enq && !deq) begin
                count <= CNT_W'(count + CNT_W'(1));
            end else if (deq && !enq) begin
                count <= CNT_W'(count - CNT_W'(1));
            end
        end
    end

endmodule

// File: doc/fx_writeback_unit.md
FX_WRITEBACK_UNIT -- requirements
Module: fx_writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-queue entries (power of two, >=4).
REQ-002 SHALL have parameter FXUnitCode, default 0, unit code accepted from the result bus.
REQ-003 SHALL have port clock_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port outputEnable_i  input  1  result-bus valid from FX unit.
REQ-006 SHALL have port functionalUnitCode_i  input  2  source unit code of result.
REQ-007 SHALL have port is64Bit_i  input  1  result produced in 64-bit mode.
REQ-008 SHALL have port regWritebackAddress_i  input  6  destination GPR address.
REQ-009 SHALL have port regWritebackVal_i  input  64  result value, bit 0 = MSB.
REQ-010 SHALL have port conditionRegWriteEnable_i  input  1  record form, update CR0.
REQ-011 SHALL have port carry_i  input  1  carry-out of the operation (CA).
REQ-012 SHALL have port overflow_i  input  1  signed overflow of the operation (OV).
REQ-013 SHALL have port gprWriteReady_i  input  1  register file accepts a write this cycle.
REQ-014 SHALL have port gprWriteEnable_o  output  1  write request, head entry valid.
REQ-015 SHALL have port gprWriteAddress_o  output  6  head entry address.
REQ-016 SHALL have port gprWriteData_o  output  64  head entry value.
REQ-017 SHALL have port crWriteEnable_o  output  1  CR0 write request.
REQ-018 SHALL have port crField_o  output  4  CR0 bits LT,GT,EQ,SO.
REQ-019 SHALL have port xerSO_o, xerOV_o, xerCA_o  output  1 each  architected XER bits.
REQ-020 SHALL have port stall_o  output  1  dispatch must stop issuing to FX unit.
REQ-021 SHALL have port dropError_o  output  1  one-cycle pulse, result lost on full queue.

Function
REQ-022 Enqueue SHALL occur when outputEnable_i=1, functionalUnitCode_i=FXUnitCode and (count<DEPTH or a dequeue occurs that cycle); stored: address, value, is64Bit, crEn, carry, overflow.
REQ-023 Results with any other functionalUnitCode_i SHALL be ignored with no side effect.
REQ-024 Dequeue SHALL occur when gprWriteEnable_o=1 and gprWriteReady_i=1; one entry per cycle max.
REQ-025 gprWriteEnable_o SHALL equal queue-not-empty; address/data SHALL present the head entry combinationally from registered state, 0 when empty.
REQ-026 Head outputs SHALL stay stable while gprWriteReady_i=0.
REQ-027 Entries SHALL leave in arrival order; minimum latency enqueue-to-gprWriteEnable_o is 1 cycle.
REQ-028 crWriteEnable_o SHALL equal gprWriteEnable_o AND head crEn.
REQ-029 CR0 compare: is64Bit head -> signed value[0:63]; else signed value[32:63]; LT=neg, GT=pos nonzero, EQ=zero; exactly one set.
REQ-030 crField_o SO bit SHALL equal xerSO_o OR head overflow.
REQ-031 On dequeue: xerCA_o <= head carry; xerOV_o <= head overflow; xerSO_o <= xerSO_o OR head overflow (sticky).
REQ-032 stall_o SHALL be high when count >= DEPTH-1 (one slot reserved for in-flight FX result).
REQ-033 Enqueue attempt with count=DEPTH and no same-cycle dequeue SHALL drop the result, leave queue unchanged, and pulse dropError_o next cycle.
REQ-034 Simultaneous enqueue and dequeue SHALL keep count unchanged, including at count=0 (new entry becomes head next cycle) and count=DEPTH.
REQ-035 Read/write pointers SHALL wrap modulo DEPTH; count SHALL be DEPTH+1 values wide.

Reset
REQ-036 reset_i low SHALL immediately clear pointers, count, XER bits, dropError_o; all outputs 0, regardless of clock.
REQ-037 Reset mid-operation SHALL discard all queued entries; no write request after release until a new enqueue.
REQ-038 First enqueue SHALL be accepted on the first rising edge after reset_i goes high.

Verification
REQ-039 Single result addr=5, val=0x0000_0000_0000_0007, crEn=1, is64Bit=1, ready=1 -> next cycle gprWriteEnable_o=1, addr 5, crField_o=0100, then empty.
REQ-040 is64Bit=0, val=0x0000_0001_8000_0000, crEn=1 -> crField_o=1000 (low word negative).
REQ-041 ready=0, issue 4 results (DEPTH=4) -> stall_o high from count 3; 5th result -> dropError_o pulses, queue holds first 4; ready=1 -> 4 writes in order.
REQ-042 Result overflow=1 then result overflow=0 -> after both dequeues xerOV_o=0, xerSO_o=1; second CR0 SO bit=1.
REQ-043 functionalUnitCode_i=1 with outputEnable_i=1 -> no enqueue, outputs unchanged.
REQ-044 reset_i low with 3 entries queued, clock stopped -> outputs 0 immediately; after release gprWriteEnable_o stays 0.
